// File: rtl/instr_fetch_unit.sv
// Non-pipelined instruction fetch unit: owns the PC, fetches one word at a time,
// hands it to decode and waits for the resolved next PC before fetching again.
module instr_fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] HALT_PC  = 32'd48
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
);

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    // A core whose reset vector is the halt loop never fetches at all.
    localparam state_e RESET_STATE = (RESET_PC == HALT_PC) ? ST_HALT : ST_REQ;

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic              req_valid_q, req_valid_d;
    logic              inst_valid_q, inst_valid_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;

    // Next-state, datapath capture and registered output flag computation.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_addr_d = fault_addr_q;

        case (state_q)
            ST_REQ: begin
                // Handshake uses the registered valid so the reset cycle never counts.
                if (req_valid_q && imem_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (inst_valid_q && inst_ready) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_EXEC: begin
                if (npc_valid) begin
                    if (is_misaligned(npc)) begin
                        fault_addr_d = npc;
                        state_d      = ST_FAULT;
                    end else if (npc == HALT_PC) begin
                        pc_d    = npc;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = npc;
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                // Unreachable encodings park the core safely.
                state_d = ST_FAULT;
            end
        endcase

        req_valid_d  = (state_d == ST_REQ);
        inst_valid_d = (state_d == ST_ISSUE);
        halted_d     = (state_d == ST_HALT);
        fault_d      = (state_d == ST_FAULT);
    end

    // State, PC, captured instruction and output flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= '0;
            fault_addr_q <= '0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fault_addr_q <= fault_addr_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign halted         = halted_q;
    assign fault          = fault_q;
    assign fault_addr     = fault_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: memory and decode/execute models drive the
// DUT, a program-walk model predicts fetches, and a monitor scores every handshake.
module tb_instr_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] HALT_PC  = 32'd48;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        npc_valid;
    logic [31:0] npc;
    logic        halted;
    logic        fault;
    logic [31:0] fault_addr;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .HALT_PC  (HALT_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .halted         (halted),
        .fault          (fault),
        .fault_addr     (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected fetch addresses and expected (instruction, pc) pairs.
    logic [31:0] exp_req_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_ipc_q[$];

    // Environment/model state, driven only by the main stimulus process.
    bit          zw, seq_mode;
    int          mem_lat;
    bit          pend, epend, acc_seen, iss_seen, accepted_now;
    int          cnt, ecnt, cyc, force_spur, insts_left, end_kind;
    logic [31:0] paddr, acc_addr, m_pc, exp_fault_addr;
    bit          halt_due, fault_due, done;
    int          acc_cycles[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard front.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (imem_req_valid) begin
                    if (exp_req_q.size() == 0) begin
                        chk1("req_unexpected", imem_req_valid, 1'b0);
                    end else begin
                        chk("req_addr", imem_addr, exp_req_q[0]);
                        if (imem_req_ready) void'(exp_req_q.pop_front());
                    end
                end
                if (inst_valid) begin
                    if (exp_inst_q.size() == 0) begin
                        chk1("inst_unexpected", inst_valid, 1'b0);
                    end else begin
                        chk("inst", inst, exp_inst_q[0]);
                        chk("inst_pc", inst_pc, exp_ipc_q[0]);
                        if (inst_ready) begin
                            void'(exp_inst_q.pop_front());
                            void'(exp_ipc_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Program walk: decides the next PC and records what fetch it implies.
    task automatic choose_npc(output logic [31:0] v);
        if (insts_left > 0) begin
            if (seq_mode) v = m_pc + 32'd4;
            else if ($urandom_range(0, 7) == 0) v = 32'hFFFF_FFFC;
            else begin
                v = $urandom;
                v[1:0] = 2'b00;
            end
            if (v == HALT_PC) v = 32'h0000_0100;
            insts_left--;
            m_pc = v;
            exp_req_q.push_back(v);
            exp_inst_q.push_back(mem_word(v));
            exp_ipc_q.push_back(v);
        end else if (end_kind == 0) begin
            v = HALT_PC;
            halt_due = 1'b1;
        end else begin
            v = $urandom;
            v[1:0] = 2'($urandom_range(1, 3));
            exp_fault_addr = v;
            fault_due = 1'b1;
        end
    endtask

    // One clock of the memory and decode/execute environment models.
    task automatic step();
        logic [31:0] v;
        @(posedge clk);
        #1;
        cyc++;
        accepted_now = 1'b0;
        if (halt_due) begin
            halt_due = 1'b0;
            done = 1'b1;
            chk1("halted", halted, 1'b1);
            chk1("halt_no_fault", fault, 1'b0);
            chk("halt_pc", imem_addr, HALT_PC);
        end
        if (fault_due) begin
            fault_due = 1'b0;
            done = 1'b1;
            chk1("fault", fault, 1'b1);
            chk1("fault_no_halt", halted, 1'b0);
            chk("fault_addr", fault_addr, exp_fault_addr);
            chk("fault_pc_kept", imem_addr, m_pc);
        end
        if (acc_seen) begin
            pend = 1'b1;
            paddr = acc_addr;
            cnt = zw ? 0 : ((mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 2)));
            acc_cycles.push_back(cyc);
            accepted_now = 1'b1;
        end
        imem_rsp_valid = 1'b0;
        imem_rdata = $urandom;
        if (pend) begin
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rdata = mem_word(paddr);
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end else if (force_spur > 0 || $urandom_range(0, 5) == 0) begin
            imem_rsp_valid = 1'b1;
            if (force_spur > 0) force_spur--;
        end
        imem_req_ready = zw ? 1'b1 : 1'($urandom_range(0, 1));
        acc_seen = imem_req_valid && imem_req_ready;
        acc_addr = imem_addr;

        if (iss_seen) begin
            epend = 1'b1;
            ecnt = zw ? 0 : int'($urandom_range(0, 3));
        end
        npc_valid = 1'b0;
        npc = $urandom;
        if (epend) begin
            if (ecnt == 0) begin
                choose_npc(v);
                npc_valid = 1'b1;
                npc = v;
                epend = 1'b0;
            end else begin
                ecnt--;
            end
        end else if ($urandom_range(0, 4) == 0) begin
            npc_valid = 1'b1;
        end
        inst_ready = zw ? 1'b1 : ($urandom_range(0, 2) == 0);
        iss_seen = inst_valid && inst_ready;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        inst_ready = 1'b0;
        npc_valid = 1'b0;
        npc = 32'h0;
        exp_req_q.delete();
        exp_inst_q.delete();
        exp_ipc_q.delete();
        acc_cycles.delete();
        pend = 1'b0; epend = 1'b0; acc_seen = 1'b0; iss_seen = 1'b0;
        halt_due = 1'b0; fault_due = 1'b0; done = 1'b0;
        m_pc = RESET_PC;
        #1;
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_pc", imem_addr, RESET_PC);
        repeat (2) @(negedge clk);
        exp_req_q.push_back(RESET_PC);
        exp_inst_q.push_back(mem_word(RESET_PC));
        exp_ipc_q.push_back(RESET_PC);
        force_spur = 3;
        rst_n = 1'b1;
    endtask

    task automatic run_until_done(input int bound);
        for (int k = 0; k < bound && !done; k++) step();
        chk1("done_timeout", done, 1'b1);
    endtask

    task automatic quiet(input logic exp_halt);
        int reqs;
        reqs = 0;
        repeat (20) begin
            step();
            if (imem_req_valid) reqs++;
        end
        chk("quiet_reqs", reqs, 32'd0);
        chk1("quiet_halted", halted, exp_halt);
        chk1("quiet_fault", fault, !exp_halt);
        chk("left_req", 32'(exp_req_q.size()), 32'd0);
        chk("left_inst", 32'(exp_inst_q.size()), 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        cyc = 0;
        mem_lat = -1;

        // Zero-wait sequential program ending in the halt loop.
        zw = 1'b1;
        seq_mode = 1'b1;
        @(negedge clk);
        apply_reset();
        insts_left = 6;
        end_kind = 0;
        step();
        chk1("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_addr, RESET_PC);
        run_until_done(200);
        if (acc_cycles.size() >= 2) chk("fetch_spacing", 32'(acc_cycles[1] - acc_cycles[0]), 32'd4);
        else chk("fetch_count", 32'(acc_cycles.size()), 32'd2);
        quiet(1'b1);

        // Random handshakes, then an asynchronous reset while a fetch is outstanding.
        zw = 1'b0;
        seq_mode = 1'b0;
        @(negedge clk);
        apply_reset();
        insts_left = 40;
        end_kind = 1;
        for (k = 0; k < 3000; k++) begin
            step();
            if (insts_left <= 20 && accepted_now) break;
        end
        chk1("wait_reached", accepted_now, 1'b1);
        #2;
        apply_reset();

        // Random program after the reset, ending in a misaligned target.
        insts_left = 30;
        end_kind = 1;
        run_until_done(3000);
        quiet(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential consumer of the next-PC value produced by the branch/jump resolution logic.
- Owns the architectural PC register and issues one word fetch per instruction to instruction memory over a valid/ready request and valid response channel.
- Presents the fetched instruction to decode with a valid/ready handshake, then waits for the resolved next PC before fetching again.
- Non-pipelined: at most one instruction in flight. Sits between instruction memory and decode/execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- HALT_PC, 32'd48, fetch address that halts the core (self-loop address of the test programs).
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  ADDR_W  fetch byte address; equals pc.
- imem_rsp_valid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst  out  32  captured instruction word.
- inst_pc  out  ADDR_W  PC of the presented instruction.
- npc_valid  in  1  resolved next PC valid (from next-PC logic, after execute).
- npc  in  ADDR_W  resolved next PC.
- halted  out  1  sticky halt indication.
- fault  out  1  sticky misaligned-target indication.
- fault_addr  out  ADDR_W  offending next-PC value.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; state=REQ; inst=0; fault_addr=0.
  - All valid outputs, halted and fault are 0.
  - Reset mid-transaction abandons it with no further request.
  - If RESET_PC==HALT_PC, go to HALT instead of REQ.
- States: REQ, WAIT, ISSUE, EXEC, HALT, FAULT.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On the imem_req_ready edge → WAIT.
  - imem_addr is stable while valid && !ready.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: inst<=imem_rdata, inst_pc<=pc → ISSUE.
  - A response arriving on the same cycle as acceptance (REQ) is not captured. Memory latency is ≥1 cycle.
- ISSUE:
  - inst_valid=1; inst and inst_pc held stable.
  - On inst_ready → EXEC.
- EXEC:
  - inst_valid=0; waits for npc_valid.
  - npc[1:0]!=0 → fault_addr<=npc, FAULT, pc unchanged.
  - Else pc<=npc; npc==HALT_PC → HALT, otherwise → REQ.
- HALT: halted=1, no requests, all inputs ignored until reset.
- FAULT: fault=1, no requests, all inputs ignored until reset.
- Ignored inputs:
  - npc_valid outside EXEC.
  - imem_rsp_valid outside WAIT.
  - inst_ready outside ISSUE.
- Latency: minimum 4 cycles per instruction, with zero-wait memory and immediate handshakes (REQ→WAIT→ISSUE→EXEC→REQ).
- Width and wrap: pc is ADDR_W bits; npc is taken verbatim, so no wrap arithmetic is done in this block. PC 32'hFFFF_FFFC is a legal fetch.
- All outputs are registered state or a decode of state; no combinational path from any input to any output.

Test Plan:
- Reset then zero-wait memory returning 32'h0000_0013 at addr 0; inst_ready=1; npc=4 → first request at addr 0 on the first cycle after reset release; inst=32'h13, inst_pc=0; second request at addr 4 exactly 4 cycles after the first.
- imem_req_ready held low for 3 cycles, response delayed 2 cycles → imem_addr stable throughout; exactly one request accepted; inst captured only on the rsp_valid cycle.
- inst_ready low for 5 cycles in ISSUE, with spurious npc_valid pulses → inst/inst_pc stable; npc ignored; EXEC entered only after the ready cycle.
- Branch: npc=32'h40 from pc=8 → next fetch at 0x40; then npc=48 → halted=1 one cycle later; no further imem_req_valid for 20 cycles.
- npc=32'h22 (misaligned) → fault=1, fault_addr=0x22, pc unchanged, no new request.
- Assert rst_n low while in WAIT, asynchronously mid-cycle → outputs clear immediately; after release the fetch restarts at RESET_PC; the stale imem_rsp_valid during REQ is ignored.
